pc_branch_unit: RTL and testbench

- Sits directly downstream of the CPU controller FSM; consumes its pcAdd/pcJump/pcBranch/flagWrite strobes plus the current instruction.
- Owns the program counter and the processor status flag register (C, L, F, Z, N).
- Evaluates the 4-bit condition field of Bcond/Jcond against the stored flags and updates the PC: sequential, wrap-around, or jump.
- Drives the memory fetch address and the link value used by JAL.

---
 rtl/pc_branch_unit_pkg.sv | 37 +++
 rtl/pc_branch_unit_cond_eval.sv | 49 ++++
 rtl/pc_branch_unit.sv | 92 +++++++++
 tb/tb_pc_branch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_branch_unit_pkg
// Shared condition codes, flag bit positions and the JAL subfield code.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_branch_unit_pkg;

  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_CS    = 4'b0010;
  localparam logic [3:0] COND_CC    = 4'b0011;
  localparam logic [3:0] COND_HI    = 4'b0100;
  localparam logic [3:0] COND_LS    = 4'b0101;
  localparam logic [3:0] COND_GT    = 4'b0110;
  localparam logic [3:0] COND_LE    = 4'b0111;
  localparam logic [3:0] COND_FS    = 4'b1000;
  localparam logic [3:0] COND_FC    = 4'b1001;
  localparam logic [3:0] COND_LO    = 4'b1010;
  localparam logic [3:0] COND_HS    = 4'b1011;
  localparam logic [3:0] COND_LT    = 4'b1100;
  localparam logic [3:0] COND_GE    = 4'b1101;
  localparam logic [3:0] COND_UC    = 4'b1110;
  localparam logic [3:0] COND_NEVER = 4'b1111;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] JAL_CODE = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/pc_branch_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational evaluation of a 4-bit condition code against stored flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       take
);

  logic c_flag, l_flag, f_flag, z_flag, n_flag;

  assign c_flag = flags[FLAG_C];
  assign l_flag = flags[FLAG_L];
  assign f_flag = flags[FLAG_F];
  assign z_flag = flags[FLAG_Z];
  assign n_flag = flags[FLAG_N];

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ:    take = z_flag;
      COND_NE:    take = !z_flag;
      COND_CS:    take = c_flag;
      COND_CC:    take = !c_flag;
      COND_HI:    take = l_flag;
      COND_LS:    take = !l_flag;
      COND_GT:    take = n_flag;
      COND_LE:    take = !n_flag;
      COND_FS:    take = f_flag;
      COND_FC:    take = !f_flag;
      COND_LO:    take = !l_flag && !z_flag;
      COND_HS:    take = l_flag || z_flag;
      COND_LT:    take = !n_flag && !z_flag;
      COND_GE:    take = n_flag || z_flag;
      COND_UC:    take = 1'b1;
      COND_NEVER: take = 1'b0;
      default:    take = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program counter, status flags and conditional jump/branch resolution.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             pcAdd,
  input  logic             pcJump,
  input  logic             pcBranch,
  input  logic             flagWrite,
  input  logic [4:0]       aluFlags,
  input  logic [WIDTH-1:0] regTarget,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcLink,
  output logic [4:0]       flags,
  output logic             taken,
  output logic             seqError
);

  logic             cond_take;
  logic             is_jal;
  logic             go;
  logic             strobe_conflict;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] branch_disp;
  logic [WIDTH-1:0] pc_next;
  logic             taken_next;
  logic [3:0]       unused_instr_bits;

  assign unused_instr_bits = instruction[15:12];

  // Conditions always see the registered flags, never this cycle's aluFlags.
  cond_eval u_cond_eval (
    .cond  (instruction[11:8]),
    .flags (flags),
    .take  (cond_take)
  );

  assign is_jal          = (instruction[7:4] == JAL_CODE);
  assign pc_inc          = pc + WIDTH'(1);
  assign branch_disp     = {{(WIDTH-8){instruction[7]}}, instruction[7:0]};
  assign strobe_conflict = (pcAdd && pcJump) || (pcAdd && pcBranch) || (pcJump && pcBranch);
  assign pcLink          = pc_inc;

  always_comb begin
    go         = 1'b0;
    pc_next    = pc;
    taken_next = 1'b0;
    if (pcJump) begin
      // For JAL the cond field names the link register, so it is not a condition.
      go      = cond_take || is_jal;
      pc_next = go ? regTarget : pc_inc;
    end else if (pcBranch) begin
      go      = cond_take;
      pc_next = go ? (pc + branch_disp) : pc_inc;
    end else if (pcAdd) begin
      pc_next = pc_inc;
    end
    taken_next = go;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      flags    <= '0;
      taken    <= 1'b0;
      seqError <= 1'b0;
    end else begin
      pc    <= pc_next;
      taken <= taken_next;
      if (flagWrite) begin
        flags <= aluFlags;
      end
      if (strobe_conflict) begin
        seqError <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
// Directed and randomized checks of pc_branch_unit against a reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = '0;
  logic        pcAdd = 1'b0;
  logic        pcJump = 1'b0;
  logic        pcBranch = 1'b0;
  logic        flagWrite = 1'b0;
  logic [4:0]  aluFlags = '0;
  logic [15:0] regTarget = '0;
  logic [15:0] pc;
  logic [15:0] pcLink;
  logic [4:0]  flags;
  logic        taken;
  logic        seqError;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_pc = '0;
  logic [4:0]  m_flags = '0;
  logic        m_taken = 1'b0;
  logic        m_seq = 1'b0;

  pc_branch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .pcAdd(pcAdd), .pcJump(pcJump), .pcBranch(pcBranch),
    .flagWrite(flagWrite), .aluFlags(aluFlags), .regTarget(regTarget),
    .pc(pc), .pcLink(pcLink), .flags(flags), .taken(taken), .seqError(seqError)
  );

  always #5 clk = ~clk;

  // Condition table written directly from the named flag meanings.
  function automatic bit model_cond(input logic [3:0] c, input logic [4:0] f);
    bit cf, lf, ff, zf, nf;
    cf = f[4]; lf = f[3]; ff = f[2]; zf = f[1]; nf = f[0];
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance model by one edge using the currently driven inputs, then wait.
  task automatic tick();
    logic [15:0] n_pc;
    logic [4:0]  n_flags;
    logic        n_taken, n_seq;
    int          disp, nstrobe;
    bit          go;
    n_pc = m_pc; n_flags = m_flags; n_taken = 0; n_seq = m_seq;
    if (reset) begin
      n_pc = 16'h0000; n_flags = 0; n_seq = 0;
    end else begin
      nstrobe = int'(pcAdd) + int'(pcJump) + int'(pcBranch);
      if (nstrobe > 1) n_seq = 1;
      disp = int'(instruction[7:0]);
      if (disp >= 128) disp = disp - 256;
      if (pcJump) begin
        go = (instruction[7:4] == 4'b1000) || model_cond(instruction[11:8], m_flags);
        n_pc = go ? regTarget : 16'((int'(m_pc) + 1) % 65536);
      end else if (pcBranch) begin
        go = model_cond(instruction[11:8], m_flags);
        n_pc = go ? 16'((int'(m_pc) + disp + 65536) % 65536) : 16'((int'(m_pc) + 1) % 65536);
      end else begin
        go = 0;
        if (pcAdd) n_pc = 16'((int'(m_pc) + 1) % 65536);
      end
      n_taken = go;
      if (flagWrite) n_flags = aluFlags;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_flags = n_flags; m_taken = n_taken; m_seq = n_seq;
  endtask

  task automatic idle_inputs();
    reset = 0; pcAdd = 0; pcJump = 0; pcBranch = 0; flagWrite = 0;
  endtask

  // Force pc to a value via an unconditional jump.
  task automatic set_pc(input logic [15:0] v);
    idle_inputs();
    pcJump = 1; instruction = 16'h4EC5; regTarget = v;
    tick();
    idle_inputs();
  endtask

  task automatic set_flags(input logic [4:0] v);
    idle_inputs();
    flagWrite = 1; aluFlags = v;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1; pcAdd = 1;
    tick();
    checks++;
    if (pc !== 16'h0000 || flags !== 5'b0 || taken !== 1'b0 || seqError !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pc=%h flags=%b taken=%b seqError=%b required pc=0000 flags=00000 taken=0 seqError=0",
               pc, flags, taken, seqError);
    end
    reset = 0;
    repeat (3) tick();
    checks++;
    if (pc !== 16'h0003) begin
      failures++;
      $display("FAIL reset_then_add3 pc=%h required 0003", pc);
    end
    checks++;
    if (pcLink !== 16'h0004) begin
      failures++;
      $display("FAIL pclink pcLink=%h required 0004", pcLink);
    end
    idle_inputs();
    tick();
    checks++;
    if (pc !== 16'h0003) begin
      failures++;
      $display("FAIL hold_no_strobe pc=%h required 0003", pc);
    end
  endtask

  task automatic test_branch();
    set_flags(5'b00010);
    set_pc(16'h0010);
    pcBranch = 1; instruction = 16'hC0FC;
    tick();
    checks++;
    if (pc !== 16'h000C || taken !== 1'b1) begin
      failures++;
      $display("FAIL branch_eq_taken pc=%h taken=%b required pc=000c taken=1", pc, taken);
    end
    idle_inputs();
    tick();
    checks++;
    if (taken !== 1'b0 || pc !== 16'h000C) begin
      failures++;
      $display("FAIL taken_one_cycle pc=%h taken=%b required pc=000c taken=0", pc, taken);
    end
    set_pc(16'h0010);
    pcBranch = 1; instruction = 16'hC1FC;
    tick();
    checks++;
    if (pc !== 16'h0011 || taken !== 1'b0) begin
      failures++;
      $display("FAIL branch_ne_not_taken pc=%h taken=%b required pc=0011 taken=0", pc, taken);
    end
    idle_inputs();
  endtask

  task automatic test_jump();
    pcJump = 1; instruction = 16'h4EC5; regTarget = 16'h1234;
    tick();
    checks++;
    if (pc !== 16'h1234 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jump_uc pc=%h taken=%b required pc=1234 taken=1", pc, taken);
    end
    set_flags(5'b00000);
    pcJump = 1; instruction = 16'h4381; regTarget = 16'hBEEF;
    tick();
    checks++;
    if (pc !== 16'hBEEF) begin
      failures++;
      $display("FAIL jal_form pc=%h required beef", pc);
    end
    // JAL with the never-code in the cond field must still jump.
    pcJump = 1; instruction = 16'h4F81; regTarget = 16'h0420;
    tick();
    checks++;
    if (pc !== 16'h0420 || taken !== 1'b1) begin
      failures++;
      $display("FAIL jal_override pc=%h taken=%b required pc=0420 taken=1", pc, taken);
    end
    pcJump = 1; instruction = 16'h4F25; regTarget = 16'h7777;
    tick();
    checks++;
    if (pc !== 16'h0421 || taken !== 1'b0) begin
      failures++;
      $display("FAIL jump_never pc=%h taken=%b required pc=0421 taken=0", pc, taken);
    end
    idle_inputs();
  endtask

  task automatic test_flag_ordering();
    set_flags(5'b00000);
    set_pc(16'h0100);
    pcBranch = 1; instruction = 16'h00FC; flagWrite = 1; aluFlags = 5'b00010;
    tick();
    checks++;
    if (pc !== 16'h0101 || taken !== 1'b0 || flags !== 5'b00010) begin
      failures++;
      $display("FAIL flag_order pc=%h taken=%b flags=%b required pc=0101 taken=0 flags=00010",
               pc, taken, flags);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_conflict();
    set_pc(16'hFFFF);
    checks++;
    if (pcLink !== 16'h0000) begin
      failures++;
      $display("FAIL pclink_wrap pcLink=%h required 0000", pcLink);
    end
    pcAdd = 1;
    tick();
    checks++;
    if (pc !== 16'h0000) begin
      failures++;
      $display("FAIL pc_wrap pc=%h required 0000", pc);
    end
    set_pc(16'h0002);
    pcBranch = 1; instruction = 16'h0EFC;
    tick();
    checks++;
    if (pc !== 16'hFFFE) begin
      failures++;
      $display("FAIL branch_wrap pc=%h required fffe", pc);
    end
    set_pc(16'h0040);
    checks++;
    if (seqError !== 1'b0) begin
      failures++;
      $display("FAIL seq_clear_before seqError=%b required 0", seqError);
    end
    pcAdd = 1; pcBranch = 1; instruction = 16'h0E02;
    tick();
    checks++;
    if (pc !== 16'h0042 || seqError !== 1'b1) begin
      failures++;
      $display("FAIL conflict pc=%h seqError=%b required pc=0042 seqError=1", pc, seqError);
    end
    idle_inputs();
    pcAdd = 1;
    repeat (4) tick();
    checks++;
    if (seqError !== 1'b1) begin
      failures++;
      $display("FAIL seq_sticky seqError=%b required 1", seqError);
    end
    reset = 1;
    tick();
    checks++;
    if (seqError !== 1'b0 || pc !== 16'h0000) begin
      failures++;
      $display("FAIL seq_reset seqError=%b pc=%h required seqError=0 pc=0000", seqError, pc);
    end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        set_flags(5'(f));
        pcBranch = 1;
        instruction = {4'h0, 4'(c), 8'(($urandom % 256))};
        tick();
        checks++;
        if (taken !== m_taken || pc !== m_pc) begin
          failures++;
          $display("FAIL cond_sweep cond=%0d flags=%b taken=%b pc=%h required taken=%b pc=%h",
                   c, 5'(f), taken, pc, m_taken, m_pc);
        end
        if (c == 15 || c == 14) begin
          checks++;
          if (taken !== (c == 14)) begin
            failures++;
            $display("FAIL cond_fixed cond=%0d taken=%b required %b", c, taken, (c == 14));
          end
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_link;
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom % 50) == 0;
      pcAdd       = ($urandom % 3) == 0;
      pcJump      = ($urandom % 5) == 0;
      pcBranch    = ($urandom % 4) == 0;
      flagWrite   = ($urandom % 3) == 0;
      aluFlags    = 5'($urandom);
      instruction = 16'($urandom);
      regTarget   = 16'($urandom);
      tick();
      exp_link = m_pc + 16'd1;
      checks++;
      if (pc !== m_pc || flags !== m_flags || taken !== m_taken || seqError !== m_seq || pcLink !== exp_link) begin
        failures++;
        $display("FAIL random_%0d pc=%h flags=%b taken=%b seq=%b link=%h required pc=%h flags=%b taken=%b seq=%b link=%h",
                 i, pc, flags, taken, seqError, pcLink, m_pc, m_flags, m_taken, m_seq, exp_link);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_branch();
    test_jump();
    test_flag_ordering();
    test_wrap_conflict();
    test_cond_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
